// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encoding and address-field helpers for the direct-mapped data cache.
package dcache_pkg;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;
  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << OFFSET_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_e;

  function automatic logic [OFFSET_W-1:0] addr_off(input logic [31:0] a);
    return a[OFFSET_W+1:2];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_idx(input logic [31:0] a);
    return a[OFFSET_W+INDEX_W+1:OFFSET_W+2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:OFFSET_W+INDEX_W+2];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// Tag RAM, async-cleared valid bits and word-addressed data RAM.
// One combinational read port and one synchronous write port.
module dcache_array import dcache_pkg::*; (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  output logic [31:0]         rd_data_o,
  input  logic                data_we_i,
  input  logic [INDEX_W-1:0]  wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [31:0]         wr_data_i,
  input  logic                tag_we_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic                inval_i,
  input  logic [INDEX_W-1:0]  inval_idx_i
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (inval_i)  valid_q[inval_idx_i] <= 1'b0;
      if (tag_we_i) valid_q[wr_idx_i]    <= 1'b1;
    end
  end

  // Contents are deliberately not reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (tag_we_i)  tag_q[wr_idx_i] <= wr_tag_i;
    if (data_we_i) data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate cache controller: FSM, refill counter and request latches.
//   state    | meaning
//   S_IDLE   | serve hits, detect misses / stores
//   S_REFILL | fetch WORDS words of the latched line
//   S_WRITE  | forward the latched store to memory
//   S_DONE   | one unstalled cycle so the core retires the store
module dcache_ctrl import dcache_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        stall_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);
  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]    line_tag_q, line_tag_d;
  logic [INDEX_W-1:0]  line_idx_q, line_idx_d;
  logic [29:0]         wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                wr_hit_q, wr_hit_d;

  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid, hit, stall;
  logic [31:0]         rd_data;
  logic                data_we, tag_we, inval;
  logic [INDEX_W-1:0]  wr_idx;
  logic [OFFSET_W-1:0] wr_off;
  logic [31:0]         wr_data;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr_i[1:0];

  dcache_array u_array (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_idx_i   (addr_idx(cpu_addr_i)),
    .rd_off_i   (addr_off(cpu_addr_i)),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .data_we_i  (data_we),
    .wr_idx_i   (wr_idx),
    .wr_off_i   (wr_off),
    .wr_data_i  (wr_data),
    .tag_we_i   (tag_we),
    .wr_tag_i   (line_tag_q),
    .inval_i    (inval),
    .inval_idx_i(addr_idx(cpu_addr_i))
  );

  assign hit = rd_valid && (rd_tag == addr_tag(cpu_addr_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      line_tag_q <= '0;
      line_idx_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_hit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_tag_q <= line_tag_d;
      line_idx_q <= line_idx_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_hit_q   <= wr_hit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_tag_d  = line_tag_q;
    line_idx_d  = line_idx_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_hit_d    = wr_hit_q;
    stall       = 1'b0;
    cpu_rdata_o = '0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    inval       = 1'b0;
    wr_idx      = line_idx_q;
    wr_off      = cnt_q;
    wr_data     = mem_rdata_i;
    case (state_q)
      S_IDLE: begin
        if (cpu_wr_i) begin
          stall     = 1'b1;
          wr_addr_d = cpu_addr_i[31:2];
          wr_data_d = cpu_wdata_i;
          wr_hit_d  = hit;
          state_d   = S_WRITE;
        end else if (cpu_rd_i) begin
          if (hit) begin
            cpu_rdata_o = rd_data;
          end else begin
            stall      = 1'b1;
            line_tag_d = addr_tag(cpu_addr_i);
            line_idx_d = addr_idx(cpu_addr_i);
            inval      = 1'b1;
            cnt_d      = '0;
            state_d    = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        stall      = 1'b1;
        mem_rd_o   = 1'b1;
        mem_addr_o = {line_tag_q, line_idx_q, cnt_q, 2'b00};
        if (mem_ready_i) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          // Line becomes valid only with its last word, so an aborted refill leaves it invalid.
          if (cnt_q == OFFSET_W'(WORDS - 1)) begin
            tag_we  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        stall       = 1'b1;
        mem_wr_o    = 1'b1;
        mem_addr_o  = {wr_addr_q, 2'b00};
        mem_wdata_o = wr_data_q;
        wr_idx      = addr_idx({wr_addr_q, 2'b00});
        wr_off      = addr_off({wr_addr_q, 2'b00});
        wr_data     = wr_data_q;
        if (mem_ready_i) begin
          data_we = wr_hit_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A request held through reset must not see stall.
  assign stall_o = stall & rst_ni;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a line-level cache model, a latency-3 memory and a per-cycle bus checker.
module tb_dcache_ctrl;
  localparam int LAT   = 3;
  localparam int WORDS = 4;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        stall, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int n_pass = 0, n_chk = 0;
  int wcnt = 0, done_cnt = 0;

  bit          mvalid [32];
  logic [22:0] mtag   [32];
  logic [31:0] mdata  [32][WORDS];
  logic [31:0] memw   [int];
  req_t        exp_q  [$];

  dcache_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cpu_rd_i   (cpu_rd),
    .cpu_wr_i   (cpu_wr),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata),
    .stall_o    (stall),
    .mem_rd_o   (mem_rd),
    .mem_wr_o   (mem_wr),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] memval(input int k);
    if (memw.exists(k)) return memw[k];
    return 32'hA000_0000 + k;
  endfunction

  // Memory model and bus checker: ready on the LAT-th cycle of each request.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (!rst_n) begin
      wcnt = 0;
      check("rst_bus_quiet", {30'd0, mem_rd, mem_wr}, 32'd0);
    end else if (mem_rd || mem_wr) begin
      check("mem_rd_wr_excl", {31'd0, mem_rd && mem_wr}, 32'd0);
      check("mem_req_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("mem_req_kind", {31'd0, mem_wr}, {31'd0, exp_q[0].is_wr});
        check("mem_addr", mem_addr, exp_q[0].addr);
        if (exp_q[0].is_wr) check("mem_wdata", mem_wdata, exp_q[0].data);
      end
      wcnt++;
      if (wcnt == LAT) begin
        wcnt      = 0;
        mem_ready = 1'b1;
        mem_rdata = memval(int'(mem_addr >> 2));
        if (mem_wr) memw[int'(mem_addr >> 2)] = mem_wdata;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        done_cnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic do_read(input logic [31:0] a, output int nst, output logic [31:0] rd);
    int  idx = int'(a[8:4]);
    int  off = int'(a[3:2]);
    bit  hit = mvalid[idx] && (mtag[idx] == a[31:9]);
    int  exp_st = hit ? 0 : 1 + WORDS * LAT;
    req_t r;
    if (!hit) begin
      for (int w = 0; w < WORDS; w++) begin
        r.is_wr = 1'b0;
        r.addr  = {a[31:4], 4'b0} + 32'(4 * w);
        r.data  = '0;
        exp_q.push_back(r);
        mdata[idx][w] = memval(int'(r.addr >> 2));
      end
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[31:9];
    end
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = a;
    nst = 0;
    @(negedge clk);
    while (stall && nst < 200) begin
      nst++;
      @(negedge clk);
    end
    rd = cpu_rdata;
    check("rd_stall_cycles", nst, exp_st);
    check("rd_data", rd, mdata[idx][off]);
    check("rd_mem_done", exp_q.size(), 0);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int nst);
    int  idx = int'(a[8:4]);
    int  off = int'(a[3:2]);
    bit  hit = mvalid[idx] && (mtag[idx] == a[31:9]);
    req_t r;
    r.is_wr = 1'b1; r.addr = a; r.data = d;
    exp_q.push_back(r);
    if (hit) mdata[idx][off] = d;
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
    nst = 0;
    @(negedge clk);
    while (stall && nst < 200) begin
      nst++;
      @(negedge clk);
    end
    check("wr_stall_cycles", nst, 1 + LAT);
    check("wr_mem_done", exp_q.size(), 0);
    @(posedge clk); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic do_read_abort(input logic [31:0] a, input int nwords);
    int   start, guard;
    req_t r;
    for (int w = 0; w < WORDS; w++) begin
      r.is_wr = 1'b0;
      r.addr  = {a[31:4], 4'b0} + 32'(4 * w);
      r.data  = '0;
      exp_q.push_back(r);
    end
    start = done_cnt;
    guard = 0;
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = a;
    while (done_cnt - start < nwords && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("abort_words_done", done_cnt - start, nwords);
    #1;
    rst_n = 1'b0; cpu_rd = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int          nst;
    logic [31:0] rd;
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;

    // Request held through reset must be ignored.
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    repeat (4) begin
      @(negedge clk);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; cpu_rd = 1'b0;

    do_read(32'h40, nst, rd);
    check("lit_miss_penalty", nst, 13);
    check("lit_rd_40", rd, 32'hA000_0010);
    do_read(32'h44, nst, rd);
    check("lit_hit_stall", nst, 0);
    check("lit_rd_44", rd, 32'hA000_0011);

    do_write(32'h48, 32'hDEAD_BEEF, nst);
    check("lit_wr_stall", nst, 4);
    do_read(32'h48, nst, rd);
    check("lit_rd_48", rd, 32'hDEAD_BEEF);

    do_write(32'h200, 32'h1234_5678, nst);
    do_read(32'h200, nst, rd);
    check("lit_rd_200_miss", nst, 13);
    check("lit_rd_200", rd, 32'h1234_5678);
    do_read(32'h204, nst, rd);
    check("lit_rd_204", rd, 32'hA000_0081);

    repeat (2) begin
      @(negedge clk);
      check("idle_stall", {31'd0, stall}, 32'd0);
    end

    do_read(32'h240, nst, rd);
    check("lit_rd_240", rd, 32'hA000_0090);
    do_read(32'h40, nst, rd);
    check("lit_conflict_miss", nst, 13);

    do_read_abort(32'h80, 2);
    do_read(32'h80, nst, rd);
    check("lit_refetch_miss", nst, 13);
    check("lit_rd_80", rd, 32'hA000_0020);
    do_read(32'h8C, nst, rd);
    check("lit_rd_8c", rd, 32'hA000_0023);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
